instr_fetch_split: RTL and testbench
====================================

INSTR_FETCH_SPLIT -- requirements
Module: instr_fetch_split

Interface
REQ-001 The block SHALL have one clock, `clk`, with all state updated on its rising edge.
REQ-002 Reset SHALL be asynchronous and active-low on port `rst_n`.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- CS_PC_load  in  1  request fetch of word at PC
- CS_Ins_load  in  1  qualifies fetch; capture into IR/imm
- CS_PC_inc  in  1  advance PC by 1
- rom_data  in  16  instruction ROM read data
- rom_ack  in  1  rom_data valid this cycle
- rom_req  out  1  ROM read request, held until ack
- rom_addr  out  8  ROM address, stable while rom_req=1
- CS_opcode  out  4  IR[15:12] to control FSM
- rd_addr  out  3  IR[11:9]
- rs_addr  out  3  IR[8:6]
- imm_data  out  16  second word of 2-byte instruction
- two_byte  out  1  IR holds MVI/LDA, second word pending
- ins_valid  out  1  one-cycle pulse after any capture
- fetch_busy  out  1  high in FETCH state
- pc_out  out  8  current PC
- fetch_err  out  1  sticky timeout flag

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and FETCH.
REQ-005 In IDLE, CS_PC_load=1 with CS_Ins_load=1 SHALL move to FETCH next cycle with rom_req=1 and rom_addr = PC sampled on the request edge.
REQ-006 CS_PC_load without CS_Ins_load SHALL be ignored.
REQ-007 In FETCH, rom_req and rom_addr SHALL hold until rom_ack=1.
REQ-008 On the rom_ack cycle, capture SHALL happen as follows, then the FSM returns to IDLE:
- two_byte=0: rom_data latched into IR.
- two_byte=1: rom_data latched into imm_data.
REQ-009 ins_valid SHALL pulse high for exactly the one cycle following the capture edge.
REQ-010 two_byte SHALL set when a captured IR opcode is 4'b1100 (MVI) or 4'b1101 (LDA), and SHALL clear when imm_data is captured.
REQ-011 CS_opcode, rd_addr and rs_addr SHALL be combinational slices of IR; IR SHALL NOT change during an imm capture.
REQ-012 CS_PC_inc in IDLE SHALL increment PC by 1 next cycle, modulo 256 (8'hFF wraps to 8'h00).
REQ-013 CS_PC_inc in the same IDLE cycle as a fetch request SHALL increment PC while the fetch uses the pre-increment PC.
REQ-014 CS_PC_inc received in FETCH SHALL be recorded as one pending increment and applied on the cycle the FSM returns to IDLE; multiple incs in one FETCH SHALL count once.
REQ-015 Fetch requests received in FETCH SHALL be ignored (no queueing).
REQ-016 rom_ack received in IDLE SHALL be ignored.

Reset
REQ-017 On rst_n=0, outputs SHALL go to these values immediately, independent of clk:
- state=IDLE, PC=0, rom_req=0, rom_addr=0
- IR=16'hF000, so CS_opcode=4'b1111 (unused opcode)
- imm_data=0, two_byte=0, ins_valid=0, fetch_busy=0, fetch_err=0
- pending increment cleared
REQ-018 Reset asserted mid-FETCH SHALL abort the fetch; a later rom_ack SHALL capture nothing.

Configuration
REQ-019 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL run in FETCH. If 15 cycles pass with no rom_ack, the block SHALL:
- drop rom_req and return to IDLE;
- leave IR, imm_data and two_byte unchanged;
- set fetch_err (sticky until reset);
- not pulse ins_valid;
- still apply any pending increment.
REQ-020 Macro FETCH_TIMEOUT_EN undefined: FETCH SHALL wait for rom_ack indefinitely and fetch_err SHALL be tied 0.

Verification
REQ-021 The bench SHALL cover these scenarios (stimulus -> required response):
- Reset released, no stimulus -> CS_opcode=4'hF, pc_out=0, rom_req=0, ins_valid=0.
- PC=3, CS_PC_load+CS_Ins_load, rom_ack 2 cycles later with 16'h0A40 -> rom_addr=3, CS_opcode=0, rd_addr=5, rs_addr=1, one-cycle ins_valid, two_byte=0.
- Fetch 16'hC200 then fetch 16'h1234 -> two_byte=1 after first capture; imm_data=16'h1234, two_byte=0, CS_opcode still 4'hC after second.
- PC=8'hFF, CS_PC_inc in IDLE -> pc_out=0; CS_PC_inc three times during FETCH -> pc_out +1 only after ack.
- Fetch and CS_PC_inc together at PC=7 -> rom_addr=7, pc_out=8.
- FETCH_TIMEOUT_EN defined, no rom_ack -> rom_req drops after 15 cycles, fetch_err=1, IR unchanged; rst_n low mid-FETCH -> rom_req=0 immediately.

Source files
------------

// File: rtl/instr_fetch_split.sv
// Instruction fetch front-end: PC, ROM request/ack handshake, IR and immediate capture.
// Define FETCH_TIMEOUT_EN to abort a FETCH after 15 cycles without rom_ack.
module instr_fetch_split (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CS_PC_load,
    input  logic        CS_Ins_load,
    input  logic        CS_PC_inc,
    input  logic [15:0] rom_data,
    input  logic        rom_ack,
    output logic        rom_req,
    output logic [7:0]  rom_addr,
    output logic [3:0]  CS_opcode,
    output logic [2:0]  rd_addr,
    output logic [2:0]  rs_addr,
    output logic [15:0] imm_data,
    output logic        two_byte,
    output logic        ins_valid,
    output logic        fetch_busy,
    output logic [7:0]  pc_out,
    output logic        fetch_err
);
    typedef enum logic {IDLE, FETCH} state_t;

    localparam logic [15:0] IR_RESET = 16'hF000;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] imm_q, imm_d;
    logic        two_byte_q, two_byte_d;
    logic        valid_q, valid_d;
    logic        pend_q, pend_d;
    logic        finish;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        two_byte_d = two_byte_q;
        valid_d    = 1'b0;
        pend_d     = pend_q;
        finish     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (CS_PC_load && CS_Ins_load) begin
                    state_d = FETCH;
                    addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
                if (CS_PC_inc) begin
                    pc_d = pc_q + 8'd1;
                end
            end
            FETCH: begin
                pend_d = pend_q | CS_PC_inc;
                if (rom_ack) begin
                    // The second word of MVI/LDA goes to imm; IR keeps the opcode.
                    if (two_byte_q) begin
                        imm_d      = rom_data;
                        two_byte_d = 1'b0;
                    end else begin
                        ir_d       = rom_data;
                        two_byte_d = (rom_data[15:12] == 4'b1100) || (rom_data[15:12] == 4'b1101);
                    end
                    valid_d = 1'b1;
                    finish  = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == 4'd14) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
                if (finish) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    if (pend_q || CS_PC_inc) begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= 8'd0;
            addr_q     <= 8'd0;
            ir_q       <= IR_RESET;
            imm_q      <= 16'd0;
            two_byte_q <= 1'b0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            two_byte_q <= two_byte_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign rom_req    = (state_q == FETCH);
    assign fetch_busy = (state_q == FETCH);
    assign rom_addr   = addr_q;
    assign CS_opcode  = ir_q[15:12];
    assign rd_addr    = ir_q[11:9];
    assign rs_addr    = ir_q[8:6];
    assign imm_data   = imm_q;
    assign two_byte   = two_byte_q;
    assign ins_valid  = valid_q;
    assign pc_out     = pc_q;
endmodule

// File: tb/tb_instr_fetch_split.sv
// Bench for instr_fetch_split: cycle-level reference model plus directed literal checks.
module tb_instr_fetch_split;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CS_PC_load = 1'b0, CS_Ins_load = 1'b0, CS_PC_inc = 1'b0;
    logic [15:0] rom_data = 16'd0;
    logic        rom_ack = 1'b0;
    logic        rom_req, ins_valid, two_byte, fetch_busy, fetch_err;
    logic [7:0]  rom_addr, pc_out;
    logic [3:0]  CS_opcode;
    logic [2:0]  rd_addr, rs_addr;
    logic [15:0] imm_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_split dut (
        .clk(clk), .rst_n(rst_n), .CS_PC_load(CS_PC_load), .CS_Ins_load(CS_Ins_load),
        .CS_PC_inc(CS_PC_inc), .rom_data(rom_data), .rom_ack(rom_ack), .rom_req(rom_req),
        .rom_addr(rom_addr), .CS_opcode(CS_opcode), .rd_addr(rd_addr), .rs_addr(rs_addr),
        .imm_data(imm_data), .two_byte(two_byte), .ins_valid(ins_valid),
        .fetch_busy(fetch_busy), .pc_out(pc_out), .fetch_err(fetch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be, tracked per cycle from the stated rules.
    bit          m_busy, m_two, m_valid, m_pend, m_err;
    logic [7:0]  m_pc, m_addr;
    logic [15:0] m_ir, m_imm;
    int          m_wait;
    bit          m_timeout_en;
`ifdef FETCH_TIMEOUT_EN
    initial m_timeout_en = 1'b1;
`else
    initial m_timeout_en = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        bit done;
        if (!rst_n) begin
            m_busy = 0; m_two = 0; m_valid = 0; m_pend = 0; m_err = 0;
            m_pc = 8'd0; m_addr = 8'd0; m_ir = 16'hF000; m_imm = 16'd0; m_wait = 0;
        end else begin
            m_valid = 0;
            done = 0;
            if (!m_busy) begin
                if (CS_PC_load && CS_Ins_load) begin
                    m_busy = 1; m_addr = m_pc; m_wait = 0;
                end
                if (CS_PC_inc) m_pc = m_pc + 8'd1;
            end else begin
                if (CS_PC_inc) m_pend = 1;
                if (rom_ack) begin
                    if (m_two) begin
                        m_imm = rom_data; m_two = 0;
                    end else begin
                        m_ir = rom_data;
                        m_two = (rom_data[15:12] == 4'hC) || (rom_data[15:12] == 4'hD);
                    end
                    m_valid = 1; done = 1;
                end else begin
                    m_wait++;
                    if (m_timeout_en && m_wait == 15) begin
                        m_err = 1; done = 1;
                    end
                end
                if (done) begin
                    m_busy = 0;
                    if (m_pend) m_pc = m_pc + 8'd1;
                    m_pend = 0;
                end
            end
            #1;
            check("rom_req", rom_req, m_busy);
            check("fetch_busy", fetch_busy, m_busy);
            if (m_busy) check("rom_addr", rom_addr, m_addr);
            check("ir_slices", {CS_opcode, rd_addr, rs_addr}, {m_ir[15:12], m_ir[11:9], m_ir[8:6]});
            check("imm_data", imm_data, m_imm);
            check("two_byte", two_byte, m_two);
            check("ins_valid", ins_valid, m_valid);
            check("pc_out", pc_out, m_pc);
            check("fetch_err", fetch_err, m_err);
        end
    end

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) CS_PC_inc = 1'b1;
        end
        @(negedge clk) CS_PC_inc = 1'b0;
    endtask

    // Request, hold for 'waits' idle FETCH cycles, then ack with data; ends one negedge after capture.
    task automatic fetch(input logic [15:0] d, input int waits, input logic [7:0] exp_addr, input bit with_inc);
        @(negedge clk);
        CS_PC_load = 1'b1; CS_Ins_load = 1'b1; CS_PC_inc = with_inc;
        @(negedge clk);
        CS_PC_load = 1'b0; CS_Ins_load = 1'b0; CS_PC_inc = 1'b0;
        check("lit_req_addr", {rom_req, rom_addr}, {1'b1, exp_addr});
        for (int i = 0; i < waits; i++) @(negedge clk);
        rom_ack = 1'b1; rom_data = d;
        @(negedge clk);
        rom_ack = 1'b0; rom_data = 16'hDEAD;
        check("lit_valid_pulse", {ins_valid, rom_req}, 2'b10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_reset", {CS_opcode, pc_out, rom_req, ins_valid}, {4'hF, 8'h00, 1'b0, 1'b0});
        $display("reset released: opcode=%0h pc=%0h", CS_opcode, pc_out);

        // Ack and lone PC_load in IDLE are ignored.
        @(negedge clk) begin rom_ack = 1'b1; rom_data = 16'h1111; CS_PC_load = 1'b1; end
        @(negedge clk) begin rom_ack = 1'b0; CS_PC_load = 1'b0; end
        check("lit_idle_ignore", {ins_valid, rom_req, CS_opcode}, {1'b0, 1'b0, 4'hF});

        inc_n(3);
        fetch(16'h0A40, 1, 8'd3, 1'b0);
        check("lit_0A40", {CS_opcode, rd_addr, rs_addr, two_byte}, {4'h0, 3'd5, 3'd1, 1'b0});
        @(negedge clk) check("lit_valid_one_cycle", ins_valid, 1'b0);
        $display("fetch 0A40: opcode=%0h rd=%0d rs=%0d", CS_opcode, rd_addr, rs_addr);

        fetch(16'hC200, 0, 8'd3, 1'b0);
        check("lit_mvi_two", {two_byte, CS_opcode}, {1'b1, 4'hC});
        fetch(16'h1234, 2, 8'd3, 1'b0);
        check("lit_imm", {imm_data, two_byte, CS_opcode}, {16'h1234, 1'b0, 4'hC});
        $display("MVI pair: imm=%0h two_byte=%0b", imm_data, two_byte);

        inc_n(252);
        check("lit_pc_ff", pc_out, 8'hFF);
        inc_n(1);
        check("lit_pc_wrap", pc_out, 8'h00);

        // Three incs during FETCH count once, applied at the ack.
        @(negedge clk) begin CS_PC_load = 1'b1; CS_Ins_load = 1'b1; end
        @(negedge clk) begin CS_PC_load = 1'b0; CS_Ins_load = 1'b0; CS_PC_inc = 1'b1; end
        repeat (3) @(negedge clk);
        CS_PC_inc = 1'b0;
        check("lit_pc_hold", pc_out, 8'h00);
        @(negedge clk) begin rom_ack = 1'b1; rom_data = 16'h3000; end
        @(negedge clk) rom_ack = 1'b0;
        check("lit_pc_after_ack", pc_out, 8'h01);
        $display("incs in FETCH: pc=%0h", pc_out);

        inc_n(6);
        fetch(16'h2A80, 0, 8'd7, 1'b1);
        check("lit_inc_with_fetch", pc_out, 8'h08);
        $display("fetch+inc at 7: pc=%0h", pc_out);

        // Long wait without ack.
        @(negedge clk) begin CS_PC_load = 1'b1; CS_Ins_load = 1'b1; end
        @(negedge clk) begin CS_PC_load = 1'b0; CS_Ins_load = 1'b0; end
        begin
            int hi = 0;
            for (int i = 0; i < 15; i++) begin
                if (rom_req) hi++;
                @(negedge clk);
            end
            check("lit_req_cycles", hi, 15);
        end
`ifdef FETCH_TIMEOUT_EN
        check("lit_timeout", {rom_req, fetch_err, CS_opcode}, {1'b0, 1'b1, 4'h2});
        $display("timeout: rom_req=%0b fetch_err=%0b", rom_req, fetch_err);
        repeat (2) @(negedge clk);
        check("lit_err_sticky", fetch_err, 1'b1);
`else
        check("lit_no_timeout", {rom_req, fetch_err}, {1'b1, 1'b0});
        @(negedge clk) begin rom_ack = 1'b1; rom_data = 16'h4000; end
        @(negedge clk) rom_ack = 1'b0;
        check("lit_late_ack", {CS_opcode, rom_req}, {4'h4, 1'b0});
        $display("no timeout: late ack captured opcode=%0h", CS_opcode);
`endif

        // Reset mid-FETCH aborts at once; a later ack captures nothing.
        @(negedge clk) begin CS_PC_load = 1'b1; CS_Ins_load = 1'b1; end
        @(negedge clk) begin CS_PC_load = 1'b0; CS_Ins_load = 1'b0; end
        check("lit_busy_before_rst", rom_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("lit_async_rst", {rom_req, fetch_busy, CS_opcode, pc_out, fetch_err}, {1'b0, 1'b0, 4'hF, 8'h00, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        rom_ack = 1'b1; rom_data = 16'h5555;
        @(negedge clk) rom_ack = 1'b0;
        check("lit_ack_after_rst", {ins_valid, CS_opcode, rom_req}, {1'b0, 4'hF, 1'b0});
        $display("reset mid-fetch: rom_req=%0b opcode=%0h", rom_req, CS_opcode);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
